// File: rtl/lcd_pkg.sv
// Shared timing defaults, pixel types and width helpers for the LCD scan-out block.
package lcd_pkg;

   localparam int H_ACTIVE_DEF   = 480;
   localparam int H_FP_DEF       = 2;
   localparam int H_SYNC_DEF     = 41;
   localparam int H_BP_DEF       = 2;
   localparam int V_ACTIVE_DEF   = 272;
   localparam int V_FP_DEF       = 2;
   localparam int V_SYNC_DEF     = 10;
   localparam int V_BP_DEF       = 2;
   localparam int SCALE_LOG2_DEF = 3;
   localparam logic [23:0] BORDER_DEF = 24'h000040;

   // Framebuffer is 32x32 words; each word is replicated 2^SCALE_LOG2 times per axis.
   localparam int FB_BITS = 5;
   localparam int FB_DIM  = 1 << FB_BITS;
   localparam int ADDR_W  = 2 * FB_BITS;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic win;
      logic first;
   } flags_t;

   function automatic int line_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Wide enough to hold the total and to compare against the window edge without truncation.
   function automatic int cnt_width(input int total, input int scale_log2);
      int w;
      w = $clog2(total + 1);
      return (w > FB_BITS + scale_log2 + 1) ? w : FB_BITS + scale_log2 + 1;
   endfunction

   localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/lcd_timing.sv
// Raster counters and counter-stage decode (active area, syncs, framebuffer window).
module lcd_timing
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
   parameter int HW         = 10,
   parameter int VW         = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          de0,
   output logic          hs0,
   output logic          vs0,
   output logic          win0
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int WIN     = FB_DIM << SCALE_LOG2;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign de0  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign hs0  = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs0  = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign win0 = (h_cnt < HW'(WIN)) && (v_cnt < VW'(WIN));

endmodule

// File: rtl/lcd_scanout.sv
// LCD scan-out: framebuffer addressing, two-stage alignment with the buffer read, and pin muxing.
module lcd_scanout
   import lcd_pkg::*;
#(
   parameter int          H_ACTIVE   = H_ACTIVE_DEF,
   parameter int          H_FP       = H_FP_DEF,
   parameter int          H_SYNC     = H_SYNC_DEF,
   parameter int          H_BP       = H_BP_DEF,
   parameter int          V_ACTIVE   = V_ACTIVE_DEF,
   parameter int          V_FP       = V_FP_DEF,
   parameter int          V_SYNC     = V_SYNC_DEF,
   parameter int          V_BP       = V_BP_DEF,
   parameter int          SCALE_LOG2 = SCALE_LOG2_DEF,
   parameter logic [23:0] BORDER     = BORDER_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [ADDR_W-1:0] buf_addr,
   input  logic [7:0]        buf_r,
   input  logic [7:0]        buf_g,
   input  logic [7:0]        buf_b,
   output logic              lcd_hsync,
   output logic              lcd_vsync,
   output logic              lcd_de,
   output logic [7:0]        lcd_r,
   output logic [7:0]        lcd_g,
   output logic [7:0]        lcd_b,
   output logic              frame_start
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = cnt_width(H_TOTAL, SCALE_LOG2);
   localparam int VW      = cnt_width(V_TOTAL, SCALE_LOG2);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          de0, hs0, vs0, win0, first0;
   flags_t        flags0, stage1;
   rgb_t          pix_next, pix;

   lcd_timing #(
      .H_ACTIVE   (H_ACTIVE),
      .H_FP       (H_FP),
      .H_SYNC     (H_SYNC),
      .H_BP       (H_BP),
      .V_ACTIVE   (V_ACTIVE),
      .V_FP       (V_FP),
      .V_SYNC     (V_SYNC),
      .V_BP       (V_BP),
      .SCALE_LOG2 (SCALE_LOG2),
      .HW         (HW),
      .VW         (VW)
   ) u_timing (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .h_cnt (h_cnt),
      .v_cnt (v_cnt),
      .de0   (de0),
      .hs0   (hs0),
      .vs0   (vs0),
      .win0  (win0)
   );

   assign first0   = (h_cnt == '0) && (v_cnt == '0);
   assign buf_addr = win0 ? {v_cnt[SCALE_LOG2 +: FB_BITS], h_cnt[SCALE_LOG2 +: FB_BITS]} : '0;
   assign flags0   = '{de: de0, hs: hs0, vs: vs0, win: win0, first: first0};

   // Stage 1 runs alongside the buffer read; disabling scan clears it so the pins blank one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage1 <= '0;
      end else if (!en) begin
         stage1 <= '0;
      end else begin
         stage1 <= flags0;
      end
   end

   // NOTE: default assigned first so every path drives pix_next and no latch is inferred.
   always_comb begin
      pix_next = '0;
      if (stage1.de) begin
         pix_next = stage1.win ? rgb_t'({buf_r, buf_g, buf_b}) : rgb_t'(BORDER);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcd_de      <= 1'b0;
         lcd_hsync   <= 1'b1;
         lcd_vsync   <= 1'b1;
         frame_start <= 1'b0;
         pix         <= '0;
      end else begin
         lcd_de      <= stage1.de;
         lcd_hsync   <= ~stage1.hs;
         lcd_vsync   <= ~stage1.vs;
         frame_start <= stage1.first;
         pix         <= pix_next;
      end
   end

   assign lcd_r = pix.r;
   assign lcd_g = pix.g;
   assign lcd_b = pix.b;

endmodule

// File: tb/tb_lcd_scanout.sv
// Scoreboard bench for lcd_scanout on a reduced raster; a position-level model predicts the pins.
module tb_lcd_scanout;
   import lcd_pkg::*;

   localparam int HA = 80, HFP = 2, HS = 6, HBP = 3;
   localparam int VA = 70, VFP = 2, VS = 3, VBP = 2;
   localparam int SC = 1;
   localparam logic [23:0] BRD = 24'h000040;
   localparam int HT    = HA + HFP + HS + HBP;
   localparam int VT    = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int DIM   = 32 * (2 ** SC);

   typedef struct packed {
      logic        hsync;
      logic        vsync;
      logic        de;
      logic [23:0] rgb;
      logic        fs;
   } pins_t;

   localparam pins_t BLANK = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, rgb: 24'h0, fs: 1'b0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [9:0] buf_addr;
   logic [7:0] buf_r = 8'h0, buf_g = 8'h0, buf_b = 8'h0;
   logic       lcd_hsync, lcd_vsync, lcd_de, frame_start;
   logic [7:0] lcd_r, lcd_g, lcd_b;

   always #5 clk = ~clk;

   lcd_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SCALE_LOG2(SC), .BORDER(BRD)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .buf_addr(buf_addr),
      .buf_r(buf_r), .buf_g(buf_g), .buf_b(buf_b),
      .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
      .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .frame_start(frame_start)
   );

   // Colour buffer with one cycle of read latency.
   always @(posedge clk) begin
      buf_r <= buf_addr[7:0];
      buf_g <= ~buf_addr[7:0];
      buf_b <= 8'hA5;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: scan position is a single index into the frame.
   function automatic logic [9:0] ref_addr(input int pos);
      int h, v;
      h = pos % HT;
      v = pos / HT;
      if (h < DIM && v < DIM) return 10'((v / (2 ** SC)) * 32 + (h / (2 ** SC)));
      return 10'd0;
   endfunction

   function automatic pins_t ref_pins(input int pos, input logic en_k);
      pins_t      p;
      int         h, v;
      logic [9:0] a;
      p = BLANK;
      if (en_k) begin
         h = pos % HT;
         v = pos / HT;
         a = ref_addr(pos);
         p.hsync = !(h >= HA + HFP && h < HA + HFP + HS);
         p.vsync = !(v >= VA + VFP && v < VA + VFP + VS);
         p.de    = (h < HA) && (v < VA);
         if (p.de) p.rgb = (h < DIM && v < DIM) ? {a[7:0], ~a[7:0], 8'hA5} : BRD;
         p.fs = (pos == 0);
      end
      return p;
   endfunction

   pins_t      exp_q[$];
   logic [9:0] addr_q[$];
   int         pos = 0;
   logic       mon_on = 1'b0;

   task automatic issue(input logic e);
      en = e;
      exp_q.push_back(ref_pins(pos, e));
      addr_q.push_back(ref_addr(pos));
      pos = e ? (pos + 1) % FRAME : 0;
   endtask

   task automatic step(input logic e);
      @(posedge clk);
      #1;
      issue(e);
   endtask

   // Release reset between edges; the pins stay blank for the two pipeline cycles.
   task automatic start_scan();
      @(posedge clk);
      #1;
      rst = 1'b0;
      pos = 0;
      exp_q.delete();
      addr_q.delete();
      exp_q.push_back(BLANK);
      exp_q.push_back(BLANK);
      issue(1'b1);
      mon_on = 1'b1;
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_hsync"}, lcd_hsync, 1);
      check({tag, "_vsync"}, lcd_vsync, 1);
      check({tag, "_de"}, lcd_de, 0);
      check({tag, "_rgb"}, {lcd_r, lcd_g, lcd_b}, 0);
      check({tag, "_fs"}, frame_start, 0);
      check({tag, "_addr"}, buf_addr, 0);
   endtask

   // Monitor: compare pins and address every cycle, and gather per-frame statistics.
   int   cyc = 0, last_fs = -1, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, hs_off = -1;
   int   period = 0, de_frame = 0, hs_frame = 0, vs_frame = 0, hs_off_frame = -1;
   logic hs_prev = 1'b1;

   always @(negedge clk) begin
      pins_t      act, e;
      logic [9:0] ea;
      if (mon_on) begin
         act = '{hsync: lcd_hsync, vsync: lcd_vsync, de: lcd_de,
                 rgb: {lcd_r, lcd_g, lcd_b}, fs: frame_start};
         if (exp_q.size() == 0 || addr_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
         end else begin
            e  = exp_q.pop_front();
            ea = addr_q.pop_front();
            check("pins", act, e);
            check("buf_addr", buf_addr, ea);
         end
         cyc++;
         if (frame_start) begin
            if (last_fs >= 0) begin
               period       = cyc - last_fs;
               de_frame     = de_cnt;
               hs_frame     = hs_cnt;
               vs_frame     = vs_cnt;
               hs_off_frame = hs_off;
            end
            last_fs = cyc;
            de_cnt  = 0;
            hs_cnt  = 0;
            vs_cnt  = 0;
            hs_off  = -1;
         end
         if (lcd_de) de_cnt++;
         if (!lcd_hsync) begin
            hs_cnt++;
            if (hs_prev && hs_off < 0 && last_fs >= 0) hs_off = cyc - last_fs;
         end
         if (!lcd_vsync) vs_cnt++;
         hs_prev = lcd_hsync;
      end
   end

   initial begin
      int tgt;
      int off;

      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      check_reset_pins("reset");

      // Two full frames of continuous scan.
      start_scan();
      repeat (2 * FRAME + 10) step(1'b1);
      check("frame_period", period, FRAME);
      check("de_per_frame", de_frame, HA * VA);
      check("hsync_low_per_frame", hs_frame, HS * VT);
      check("vsync_low_per_frame", vs_frame, VS * HT);
      check("hsync_fall_offset", hs_off_frame, HA + HFP);

      // Enable dropped mid-active area, then restored.
      tgt = 20 * HT + 30;
      for (int i = 0; i < FRAME && pos != tgt; i++) step(1'b1);
      check("reach_drop_point", pos, tgt);
      repeat (4) step(1'b0);
      repeat (50) step(1'b1);

      // Randomised enable gaps.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            off = $urandom_range(1, 5);
            for (int j = 0; j < off; j++) step(1'b0);
         end else begin
            step(1'b1);
         end
      end

      // Asynchronous reset between edges while the pins are showing active video.
      tgt = 30 * HT + 40;
      for (int i = 0; i < FRAME + 10 && pos != tgt; i++) step(1'b1);
      step(1'b1);
      step(1'b1);
      @(posedge clk);
      #3;
      mon_on = 1'b0;
      check("pre_reset_de", lcd_de, 1);
      rst = 1'b1;
      #1;
      check_reset_pins("async_reset");
      repeat (2) @(posedge clk);

      // Restart after reset behaves like an enable rising edge.
      start_scan();
      repeat (HT + 20) step(1'b1);
      @(posedge clk);
      #1;
      mon_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
